// File: rtl/aes_encrypt_param.sv
// Iterative AES-128/192/256 encryptor: one cipher round per clock, with the key
// schedule expanded one word per clock into a round-key register table.
module aes_encrypt_param #(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_ld,
    input  logic [255:0] key,
    output logic         key_ready,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] text_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] text_out,
    output logic         busy
);
    localparam int unsigned NK = KEY_BITS / 32;
    localparam int unsigned NR = NK + 6;
    localparam int unsigned NW = 4 * (NR + 1);
    localparam int unsigned IW = $clog2(NW);
    localparam int unsigned RW = 4;

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_encrypt_param: KEY_BITS must be 128, 192 or 256");
    end

    typedef enum logic [2:0] {S_NOKEY, S_KEXP, S_READY, S_ROUND, S_OUT} state_t;

    state_t          r_fsm, w_next;
    logic [31:0]     r_w [NW];
    logic [IW-1:0]   r_widx;
    logic [2:0]      r_kmod;
    logic [7:0]      r_rcon;
    logic [RW-1:0]   r_round;
    logic [127:0]    r_state, r_text_out;
    logic            r_key_ready, r_in_ready, r_out_valid, r_busy;
    logic [31:0]     w_prev, w_ks_in, w_ks_sub, w_temp, w_new;
    logic [127:0]    w_sb, w_sr, w_mc, w_rk, w_rk0, w_rnd;
    logic [IW-1:0]   w_rbase;
    logic            w_accept, w_unused_key;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    // Byte s(r,c) of a column-major 128-bit state.
    function automatic logic [7:0] st_byte(input logic [127:0] s, input int c, input int r);
        return s[127-8*(4*c+r) -: 8];
    endfunction

    assign w_unused_key = ^key;

    // Key schedule: one new word per KEXP cycle, r_kmod = i mod NK.
    assign w_prev  = r_w[r_widx - IW'(1)];
    assign w_ks_in = (r_kmod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    always_comb begin
        w_temp = w_prev;
        if (r_kmod == 3'd0)
            w_temp = w_ks_sub ^ {r_rcon, 24'h0};
        else if (NK == 8 && r_kmod == 3'd4)
            w_temp = w_ks_sub;
    end

    assign w_new = r_w[r_widx - IW'(NK)] ^ w_temp;

    for (genvar g = 0; g < 4; g++) begin : g_ks_sbox
        aes_sbox u_sbox (.Clk(clk), .a(w_ks_in[8*g +: 8]), .d(w_ks_sub[8*g +: 8]));
    end

    for (genvar g = 0; g < 16; g++) begin : g_dp_sbox
        aes_sbox u_sbox (.Clk(clk), .a(r_state[8*g +: 8]), .d(w_sb[8*g +: 8]));
    end

    always_comb begin
        w_sr = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                w_sr[127-8*(4*c+r) -: 8] = st_byte(w_sb, (c + r) % 4, r);
    end

    always_comb begin
        w_mc = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                w_mc[127-8*(4*c+r) -: 8] = xt(st_byte(w_sr, c, r))
                    ^ xt(st_byte(w_sr, c, (r + 1) % 4)) ^ st_byte(w_sr, c, (r + 1) % 4)
                    ^ st_byte(w_sr, c, (r + 2) % 4) ^ st_byte(w_sr, c, (r + 3) % 4);
    end

    assign w_rbase = IW'({r_round, 2'b00});
    assign w_rk    = {r_w[w_rbase], r_w[w_rbase + IW'(1)], r_w[w_rbase + IW'(2)], r_w[w_rbase + IW'(3)]};
    assign w_rk0   = {r_w[0], r_w[1], r_w[2], r_w[3]};
    assign w_rnd   = ((r_round == RW'(NR)) ? w_sr : w_mc) ^ w_rk;
    assign w_accept = (r_fsm == S_READY) && in_valid && r_in_ready && !key_ld;

    always_comb begin
        w_next = r_fsm;
        case (r_fsm)
            S_NOKEY: w_next = S_NOKEY;
            S_KEXP:  if (r_widx == IW'(NW - 1)) w_next = S_READY;
            S_READY: if (in_valid && r_in_ready) w_next = S_ROUND;
            S_ROUND: if (r_round == RW'(NR)) w_next = S_OUT;
            S_OUT:   if (out_ready) w_next = S_READY;
            default: w_next = S_NOKEY;
        endcase
        if (key_ld)
            w_next = S_KEXP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= S_NOKEY;
            r_key_ready <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_text_out  <= '0;
            r_state     <= '0;
            r_widx      <= '0;
            r_kmod      <= '0;
            r_rcon      <= '0;
            r_round     <= '0;
        end else begin
            r_fsm       <= w_next;
            r_key_ready <= (w_next == S_READY) || (w_next == S_ROUND) || (w_next == S_OUT);
            r_in_ready  <= (w_next == S_READY);
            r_out_valid <= (w_next == S_OUT);
            r_busy      <= (w_next == S_KEXP) || (w_next == S_ROUND) || (w_next == S_OUT);
            if (key_ld) begin
                r_widx  <= IW'(NK);
                r_kmod  <= '0;
                r_rcon  <= 8'h01;
                r_round <= '0;
            end else if (r_fsm == S_KEXP) begin
                r_widx <= r_widx + IW'(1);
                if (r_kmod == 3'(NK - 1)) begin
                    r_kmod <= '0;
                    r_rcon <= xt(r_rcon);
                end else begin
                    r_kmod <= r_kmod + 3'd1;
                end
            end
            if (w_accept) begin
                r_state <= text_in ^ w_rk0;
                r_round <= RW'(1);
            end else if (r_fsm == S_ROUND && !key_ld) begin
                r_state <= w_rnd;
                r_round <= r_round + RW'(1);
                if (r_round == RW'(NR))
                    r_text_out <= w_rnd;
            end
        end
    end

    // Round-key table has no reset; it is only trusted once key_ready is high.
    always_ff @(posedge clk) begin
        if (key_ld) begin
            for (int j = 0; j < NK; j++)
                r_w[IW'(j)] <= key[255-32*j -: 32];
        end else if (r_fsm == S_KEXP) begin
            r_w[r_widx] <= w_new;
        end
    end

    assign key_ready = r_key_ready;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign text_out  = r_text_out;
    assign busy      = r_busy;
endmodule

// AES S-box evaluated combinationally: GF(2^8) inverse as a^254, then the affine map.
module aes_sbox (
    input  logic       Clk,
    input  logic [7:0] a,
    output logic [7:0] d
);
    logic       w_unused_clk;
    logic [7:0] w_pow, w_inv;

    assign w_unused_clk = Clk;

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p, t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (8'h1b & {8{t[7]}});
        end
        return p;
    endfunction

    always_comb begin
        w_pow = a;
        for (int i = 0; i < 6; i++)
            w_pow = gf_mul(gf_mul(w_pow, w_pow), a);
        w_inv = gf_mul(w_pow, w_pow);
        d = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
    end
endmodule

// File: tb/tb_aes_encrypt_param.sv
// Bench for aes_encrypt_param: one instance per key size, FIPS-197 vectors, scoreboard queue.
module tb_aes_encrypt_param;
    logic         clk, rst;
    logic [2:0]   key_ld, key_ready, in_valid, in_ready, out_valid, out_ready, busy;
    logic [255:0] key [3];
    logic [127:0] text_in [3];
    logic [127:0] text_out [3];

    int           vec_cnt = 0;
    int           err_cnt = 0;
    logic [127:0] exp_q [$];
    logic [127:0] ct_fips [3];
    logic [127:0] e_v;

    localparam logic [255:0] KEY_SEQ = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_encrypt_param #(.KEY_BITS(128 + 64 * g)) u_dut (
            .clk(clk), .rst(rst), .key_ld(key_ld[g]), .key(key[g]), .key_ready(key_ready[g]),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]), .text_in(text_in[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]), .text_out(text_out[g]),
            .busy(busy[g]));
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int k, input string tag);
        chk({tag, "_key_ready"}, 128'(key_ready[k]), 0);
        chk({tag, "_in_ready"},  128'(in_ready[k]), 0);
        chk({tag, "_out_valid"}, 128'(out_valid[k]), 0);
        chk({tag, "_busy"},      128'(busy[k]), 0);
        chk({tag, "_text_out"},  text_out[k], 0);
    endtask

    task automatic load_key(input int k, input logic [255:0] kv);
        int n;
        int nk;
        nk = 4 + 2 * k;
        key[k] = kv;
        key_ld[k] = 1'b1;
        @(posedge clk);
        #1 key_ld[k] = 1'b0;
        chk("kexp_busy", 128'(busy[k]), 1);
        chk("kexp_in_ready", 128'(in_ready[k]), 0);
        n = 1;
        while (!key_ready[k] && n < 100) begin @(posedge clk); #1; n++; end
        chk("key_latency", 128'(n), 128'(4 * (nk + 7) - nk + 1));
    endtask

    task automatic send(input int k, input logic [127:0] pt, input logic [127:0] ct, input bit push);
        int n;
        n = 0;
        while (!in_ready[k] && n < 100) begin @(posedge clk); #1; n++; end
        chk("in_ready_wait", 128'(in_ready[k]), 1);
        in_valid[k] = 1'b1;
        text_in[k] = pt;
        @(posedge clk);
        if (push) exp_q.push_back(ct);
        #1 in_valid[k] = 1'b0;
    endtask

    task automatic wait_out(input int k, input int nr);
        int n;
        n = 0;
        while (!out_valid[k] && n < nr + 8) begin @(posedge clk); #1; n++; end
        chk("latency", 128'(n), 128'(nr));
        if (out_ready[k]) begin @(posedge clk); #1; end
    endtask

    // Scoreboard: every output handshake pops one expected ciphertext.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst && out_valid[k] && out_ready[k]) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected", 1, 0);
                end else begin
                    e_v = exp_q.pop_front();
                    chk("ciphertext", text_out[k], e_v);
                end
            end
        end
    end

    initial begin
        int seen;
        int n;
        ct_fips[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        ct_fips[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        ct_fips[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
        rst = 1'b1;
        key_ld = '0;
        in_valid = '0;
        out_ready = 3'b111;
        for (int k = 0; k < 3; k++) begin
            key[k] = '0;
            text_in[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk_idle(k, "reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 3; k++) begin
            load_key(k, KEY_SEQ);
            send(k, PT_C, ct_fips[k], 1'b1);
            wait_out(k, 10 + 2 * k);
        end

        load_key(0, KEY_B);
        chk("w4",  128'(g_dut[0].u_dut.r_w[4]),  128'h a0fafe17);
        chk("w43", 128'(g_dut[0].u_dut.r_w[43]), 128'h b6630ca6);
        send(0, PT_B, CT_B, 1'b1);
        wait_out(0, 10);

        // Output back-pressure with a competing input offered.
        out_ready[0] = 1'b0;
        send(0, PT_B, CT_B, 1'b1);
        wait_out(0, 10);
        in_valid[0] = 1'b1;
        text_in[0] = PT_C;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_text_out", text_out[0], CT_B);
            chk("stall_in_ready", 128'(in_ready[0]), 0);
        end
        chk("stall_out_valid", 128'(out_valid[0]), 1);
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("release_out_valid", 128'(out_valid[0]), 0);
        chk("release_in_ready", 128'(in_ready[0]), 1);

        // Key reload in the middle of a block discards it.
        send(0, PT_C, ct_fips[0], 1'b0);
        repeat (4) @(posedge clk);
        key[0] = KEY_SEQ;
        key_ld[0] = 1'b1;
        @(posedge clk);
        #1 key_ld[0] = 1'b0;
        chk("abort_out_valid", 128'(out_valid[0]), 0);
        chk("abort_key_ready", 128'(key_ready[0]), 0);
        chk("abort_busy", 128'(busy[0]), 1);
        seen = 0;
        n = 1;
        while (!key_ready[0] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid[0]) seen++;
        end
        chk("abort_no_output", 128'(seen), 0);
        chk("abort_rekey_latency", 128'(n), 41);
        send(0, PT_C, ct_fips[0], 1'b1);
        wait_out(0, 10);

        // Asynchronous reset in the middle of a block.
        send(2, PT_C, ct_fips[2], 1'b0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_idle(2, "rst_mid");
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid[2] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_in_ready", 128'(in_ready[2]), 0);
        chk("post_rst_busy", 128'(busy[2]), 0);
        chk("post_rst_out_valid", 128'(out_valid[2]), 0);
        in_valid[2] = 1'b0;

        chk("sb_drained", 128'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
